exec_datapath: RTL

- Execute-stage datapath that sits directly downstream of the pipeline control unit.
- Holds the 8-entry general register file and the ALU.
- Consumes the control unit's execute-stage controls: ra/rb/rc, reg_write, load_e, opcode_e, immediate_e, addressing_mode_e.
- Returns the ALU result (result_d) and compare flags (cmp_result) to the control unit, and store data to RAM.
- Performs register write-back for ALU ops and loads.

---
 rtl/exec_datapath_if.sv | 34 +++
 rtl/exec_datapath.sv | 99 +++++++++
 2 files changed

// File: rtl/exec_datapath_if.sv
// Control-unit <-> execute datapath bus: register addresses, execute controls,
// RAM data and the debug read port. The control unit drives through master.
interface exec_datapath_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 3,
    parameter int IMM_W  = 21
);
    logic [REG_AW-1:0] ra;
    logic [REG_AW-1:0] rb;
    logic [REG_AW-1:0] rc;
    logic              reg_write;
    logic              load_e;
    logic [3:0]        opcode_e;
    logic              addressing_mode_e;
    logic [IMM_W-1:0]  immediate_e;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] result_d;
    logic [3:0]        cmp_result;
    logic [REG_AW-1:0] dbg_sel;
    logic [DATA_W-1:0] dbg_data;

    modport master (
        output ra, rb, rc, reg_write, load_e, opcode_e, addressing_mode_e,
               immediate_e, ram_rdata, dbg_sel,
        input  ram_wdata, result_d, cmp_result, dbg_data
    );

    modport slave (
        input  ra, rb, rc, reg_write, load_e, opcode_e, addressing_mode_e,
               immediate_e, ram_rdata, dbg_sel,
        output ram_wdata, result_d, cmp_result, dbg_data
    );
endinterface

// File: rtl/exec_datapath.sv
// Execute-stage datapath: 2**REG_AW-entry register file, ALU, compare flags, write-back.
// Optional same-cycle write-back forwarding: define EXEC_DATAPATH_BYPASS_EN.
module exec_datapath #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 3,
    parameter int IMM_W  = 21
) (
    input  logic            clk,
    input  logic            reset,
    exec_datapath_if.slave  bus
);
    localparam int NREG = 1 << REG_AW;

    typedef enum logic [3:0] {
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0011,
        OP_MOV = 4'b0100,
        OP_AND = 4'b1000,
        OP_ORR = 4'b1001,
        OP_EOR = 4'b1010,
        OP_MVN = 4'b1011,
        OP_LSL = 4'b1100,
        OP_LSR = 4'b1101
    } op_e;

    logic [NREG-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [DATA_W-1:0] dbg_q, dbg_d;
    logic [DATA_W-1:0] rd_a, rd_b;
    logic [DATA_W-1:0] op_a, op_b;
    logic [DATA_W-1:0] alu_res, wb_data, st_data;
    logic [5:0]        shamt;
    logic              sh_oob;

    // Operand reads. Only load data may be forwarded into the operands: forwarding an
    // ALU write-back into its own operand would close a combinational loop.
    always_comb begin
        rd_a = regs_q[bus.ra];
        rd_b = regs_q[bus.rb];
`ifdef EXEC_DATAPATH_BYPASS_EN
        if (bus.reg_write && bus.load_e) begin
            if (bus.ra == bus.rc) rd_a = bus.ram_rdata;
            if (bus.rb == bus.rc) rd_b = bus.ram_rdata;
        end
`endif
    end

    assign op_a   = rd_a;
    assign op_b   = bus.addressing_mode_e ? rd_b : DATA_W'(bus.immediate_e);
    assign shamt  = op_b[5:0];
    assign sh_oob = int'(shamt) >= DATA_W;

    always_comb begin
        alu_res = '0;
        case (op_e'(bus.opcode_e))
            OP_MOV:  alu_res = op_b;
            OP_MVN:  alu_res = ~op_b;
            OP_AND:  alu_res = op_a & op_b;
            OP_ORR:  alu_res = op_a | op_b;
            OP_EOR:  alu_res = op_a ^ op_b;
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_LSL:  alu_res = sh_oob ? '0 : (op_a << shamt);
            OP_LSR:  alu_res = sh_oob ? '0 : (op_a >> shamt);
            default: alu_res = '0;
        endcase
    end

    assign wb_data = bus.load_e ? bus.ram_rdata : alu_res;

    // Store data and debug reads sit off the ALU path, so they can see any write-back.
    always_comb begin
        st_data = regs_q[bus.ra];
        dbg_d   = regs_q[bus.dbg_sel];
`ifdef EXEC_DATAPATH_BYPASS_EN
        if (bus.reg_write && bus.ra == bus.rc)      st_data = wb_data;
        if (bus.reg_write && bus.dbg_sel == bus.rc) dbg_d   = wb_data;
`endif
    end

    always_comb begin
        regs_d = regs_q;
        if (bus.reg_write) regs_d[bus.rc] = wb_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q <= '0;
            dbg_q  <= '0;
        end else begin
            regs_q <= regs_d;
            dbg_q  <= dbg_d;
        end
    end

    assign bus.result_d   = alu_res;
    assign bus.ram_wdata  = st_data;
    assign bus.dbg_data   = dbg_q;
    assign bus.cmp_result = {op_a > op_b, op_a < op_b, op_a != op_b, op_a == op_b};
endmodule
